fpu_addsub_scheduler: RTL

Two-port round-robin scheduler that shares one `FPU_Add_Subtract_Function` instance between two requesters, such as an accumulator and a normalisation stage. It captures the winning requester's operands, starts the FPU and waits for `ready`. It then returns the result and flags to the owner and releases the FPU with `ack_FSM`. A watchdog aborts operations that never complete.

---
 rtl/fpu_sched_pkg.sv | 10 +
 rtl/fpu_addsub_scheduler_arb.sv | 15 +
 rtl/fpu_addsub_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: shared types and constants for the FPU add/sub scheduler.
// Contents: FSM state encoding, watchdog counter width, default timeout.
package fpu_sched_pkg;

    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

    localparam int WD_W    = 8;
    localparam int TMO_DEF = 255;

endpackage

// File: rtl/fpu_addsub_scheduler_arb.sv
// rr_arbiter_2: combinational two-way round-robin winner selection.
// Ports: req (request levels), last (previous owner), any (some request set),
//        win (index of the winning requester, valid when any is set).
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       win
);

    assign any = |req;
    // requester 1 wins when it is alone, or when both ask and 0 was served last
    assign win = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/fpu_addsub_scheduler.sv
// fpu_addsub_scheduler: shares one FPU add/sub unit between two requesters.
// Ports: clk/rst (async active-high); req_i, req_x_i, req_y_i, req_op_i,
//        req_rmode_i from the requesters; gnt_o/done_o one-cycle pulses,
//        result_o/ovf_o/unf_o/err_o completion data, busy_o; fpu_* drive and
//        observe the shared FPU (beg_FSM, ack_FSM, operands, ready, result).
module fpu_addsub_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int W   = 32,
    parameter int TMO = TMO_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_i,
    input  logic [2*W-1:0] req_x_i,
    input  logic [2*W-1:0] req_y_i,
    input  logic [1:0]     req_op_i,
    input  logic [3:0]     req_rmode_i,
    output logic [1:0]     gnt_o,
    output logic [1:0]     done_o,
    output logic [W-1:0]   result_o,
    output logic           ovf_o,
    output logic           unf_o,
    output logic           err_o,
    output logic           busy_o,
    output logic           fpu_beg_o,
    output logic           fpu_ack_o,
    output logic [W-1:0]   fpu_x_o,
    output logic [W-1:0]   fpu_y_o,
    output logic           fpu_op_o,
    output logic [1:0]     fpu_rmode_o,
    input  logic           fpu_ready_i,
    input  logic           fpu_ovf_i,
    input  logic           fpu_unf_i,
    input  logic [W-1:0]   fpu_result_i
);

    state_t            state, state_n;
    logic              owner, owner_n, last, last_n;
    logic [WD_W-1:0]   wd, wd_n;
    logic [1:0]        gnt_n, done_n;
    logic [W-1:0]      result_n, x_n, y_n;
    logic              ovf_n, unf_n, err_n, beg_n, ack_n, op_n;
    logic [1:0]        rmode_n;
    logic              any, win;

    rr_arbiter_2 u_arb (.req(req_i), .last(last), .any(any), .win(win));

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        last_n   = last;
        wd_n     = wd;
        gnt_n    = 2'b00;
        done_n   = 2'b00;
        beg_n    = 1'b0;
        ack_n    = 1'b0;
        result_n = result_o;
        ovf_n    = ovf_o;
        unf_n    = unf_o;
        err_n    = err_o;
        x_n      = fpu_x_o;
        y_n      = fpu_y_o;
        op_n     = fpu_op_o;
        rmode_n  = fpu_rmode_o;
        case (state)
            IDLE: if (any) begin
                x_n     = win ? req_x_i[2*W-1:W] : req_x_i[W-1:0];
                y_n     = win ? req_y_i[2*W-1:W] : req_y_i[W-1:0];
                op_n    = win ? req_op_i[1] : req_op_i[0];
                rmode_n = win ? req_rmode_i[3:2] : req_rmode_i[1:0];
                owner_n = win;
                gnt_n   = win ? 2'b10 : 2'b01;
                beg_n   = 1'b1;
                state_n = START;
            end
            START: begin
                wd_n    = '0;
                state_n = WAIT;
            end
            WAIT: begin
                wd_n = wd + 1'b1;
                // ready takes priority over a timeout landing in the same cycle
                if (fpu_ready_i || wd_n == WD_W'(TMO)) begin
                    result_n = fpu_ready_i ? fpu_result_i : '0;
                    ovf_n    = fpu_ready_i & fpu_ovf_i;
                    unf_n    = fpu_ready_i & fpu_unf_i;
                    err_n    = ~fpu_ready_i;
                    done_n   = owner ? 2'b10 : 2'b01;
                    ack_n    = 1'b1;
                    state_n  = ACK;
                end
            end
            default: begin
                last_n  = owner;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            wd          <= '0;
            gnt_o       <= '0;
            done_o      <= '0;
            result_o    <= '0;
            ovf_o       <= 1'b0;
            unf_o       <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            fpu_beg_o   <= 1'b0;
            fpu_ack_o   <= 1'b0;
            fpu_x_o     <= '0;
            fpu_y_o     <= '0;
            fpu_op_o    <= 1'b0;
            fpu_rmode_o <= '0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            last        <= last_n;
            wd          <= wd_n;
            gnt_o       <= gnt_n;
            done_o      <= done_n;
            result_o    <= result_n;
            ovf_o       <= ovf_n;
            unf_o       <= unf_n;
            err_o       <= err_n;
            busy_o      <= state_n != IDLE;
            fpu_beg_o   <= beg_n;
            fpu_ack_o   <= ack_n;
            fpu_x_o     <= x_n;
            fpu_y_o     <= y_n;
            fpu_op_o    <= op_n;
            fpu_rmode_o <= rmode_n;
        end
    end

endmodule
